// File: rtl/udp_rx_parser.sv
// udp_rx_parser
// -------------
// Receive-side GMII parser for IPv4/UDP frames at 125 MHz. It finds the
// preamble/SFD and checks the Ethernet FCS. It filters on destination MAC,
// EtherType, IPv4 header fields and the UDP destination port. Matching
// payload bytes are streamed out as they arrive. A per-frame verdict follows
// once the frame has ended.
//
// Ports
//   clk          125 MHz GMII RX clock
//   rst          synchronous, active-high reset
//   gmii_rxd     receive data byte
//   gmii_rx_dv   receive data valid
//   gmii_rx_er   receive error
//   m_data       payload byte (1-cycle latency from the sampled input byte)
//   m_valid      payload byte strobe
//   m_sof        first payload byte of a frame (qualified by m_valid)
//   m_last       last payload byte per UDP length (qualified by m_valid)
//   frame_done   one-cycle verdict pulse for an accepted frame
//   frame_ok     verdict, valid while frame_done is high
//   ok_cnt       good-verdict frames, saturating
//   crc_err_cnt  accepted frames with FCS mismatch, saturating
//   drop_cnt     frames rejected by filter/header checks, saturating
module udp_rx_parser #(
  parameter logic [47:0] LOCAL_MAC    = 48'h02_11_22_33_44_66,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter logic [31:0] LOCAL_IP     = 32'hC0A8_F002,
  parameter logic [31:0] BCAST_IP     = 32'hC0A8_F0FF,
  parameter logic [15:0] LOCAL_PORT   = 16'd6002
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_sof,
  output logic        m_last,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [15:0] ok_cnt,
  output logic [15:0] crc_err_cnt,
  output logic [15:0] drop_cnt
);

  typedef enum logic [2:0] {
    WAIT_IDLE, HUNT, ETH, IP, UDP, PAY, TAIL, DROP
  } state_t;

  state_t      state_reg;
  logic [4:0]  idx_reg;       // byte index inside the current header section
  logic [39:0] shift_reg;     // previously received bytes, newest in [7:0]
  logic [31:0] crc_reg;
  logic        pre_seen_reg;  // at least one 0x55 seen in HUNT
  logic        er_seen_reg;
  logic        first_reg;     // next payload byte is the first one
  logic [15:0] sum_reg;       // running one's-complement IP header sum
  logic [15:0] ip_len_reg;
  logic [15:0] pay_cnt_reg;   // payload bytes still to emit

  logic [47:0] word48;
  logic [31:0] word32;
  logic [15:0] word16;
  logic [31:0] crc_next;
  logic [16:0] sum_raw;
  logic [15:0] sum_next;
  logic        crc_good;
  logic        mac_ok;
  logic        eth_fail;
  logic        ip_fail;
  logic        udp_fail;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Multi-byte fields are checked on their last byte. The current byte is
  // combined with the bytes already held in the shift register.
  always_comb begin
    word48   = {shift_reg, gmii_rxd};
    word32   = word48[31:0];
    word16   = word48[15:0];
    crc_next = crc_byte(crc_reg, gmii_rxd);
    crc_good = (crc_reg == 32'hDEBB_20E3);

    // End-around carry. A single fold cannot overflow again.
    sum_raw  = {1'b0, sum_reg} + {1'b0, word16};
    sum_next = sum_raw[15:0] + {15'h0, sum_raw[16]};

    mac_ok   = (word48 == LOCAL_MAC) || (ACCEPT_BCAST && (word48 == 48'hFFFF_FFFF_FFFF));

    eth_fail = ((idx_reg == 5'd5) && !mac_ok) ||
               ((idx_reg == 5'd13) && (word16 != 16'h0800));

    ip_fail  = ((idx_reg == 5'd0) && (gmii_rxd != 8'h45)) ||
               ((idx_reg == 5'd7) && ((word16 & 16'h3FFF) != 16'h0000)) ||
               ((idx_reg == 5'd9) && (gmii_rxd != 8'd17)) ||
               ((idx_reg == 5'd19) &&
                (((word32 != LOCAL_IP) && (word32 != BCAST_IP)) || (sum_next != 16'hFFFF)));

    udp_fail = ((idx_reg == 5'd3) && (word16 != LOCAL_PORT)) ||
               ((idx_reg == 5'd5) &&
                ((word16 < 16'd8) || (({1'b0, word16} + 17'd20) != {1'b0, ip_len_reg})));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= WAIT_IDLE;
      idx_reg      <= '0;
      shift_reg    <= '0;
      crc_reg      <= '0;
      pre_seen_reg <= 1'b0;
      er_seen_reg  <= 1'b0;
      first_reg    <= 1'b0;
      sum_reg      <= '0;
      ip_len_reg   <= '0;
      pay_cnt_reg  <= '0;
      m_data       <= '0;
      m_valid      <= 1'b0;
      m_sof        <= 1'b0;
      m_last       <= 1'b0;
      frame_done   <= 1'b0;
      frame_ok     <= 1'b0;
      ok_cnt       <= '0;
      crc_err_cnt  <= '0;
      drop_cnt     <= '0;
    end else begin
      m_valid    <= 1'b0;
      m_sof      <= 1'b0;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;

      if (gmii_rx_dv) begin
        shift_reg <= word48[39:0];
      end

      // The CRC covers every byte after the SFD, including the FCS.
      if (gmii_rx_dv && (state_reg inside {ETH, IP, UDP, PAY, TAIL})) begin
        crc_reg     <= crc_next;
        er_seen_reg <= er_seen_reg | gmii_rx_er;
      end

      case (state_reg)
        WAIT_IDLE: begin
          if (!gmii_rx_dv) state_reg <= HUNT;
        end

        HUNT: begin
          if (!gmii_rx_dv) begin
            pre_seen_reg <= 1'b0;
          end else if (gmii_rxd == 8'h55) begin
            pre_seen_reg <= 1'b1;
          end else if ((gmii_rxd == 8'hD5) && pre_seen_reg) begin
            state_reg    <= ETH;
            crc_reg      <= 32'hFFFF_FFFF;
            idx_reg      <= '0;
            er_seen_reg  <= 1'b0;
            pre_seen_reg <= 1'b0;
          end else begin
            // Not a preamble we can lock onto; not counted as a drop.
            state_reg    <= DROP;
            pre_seen_reg <= 1'b0;
          end
        end

        ETH: begin
          if (!gmii_rx_dv) begin
            drop_cnt  <= sat_inc(drop_cnt);
            state_reg <= HUNT;
          end else if (eth_fail) begin
            drop_cnt  <= sat_inc(drop_cnt);
            state_reg <= DROP;
          end else if (idx_reg == 5'd13) begin
            state_reg <= IP;
            idx_reg   <= '0;
            sum_reg   <= '0;
          end else begin
            idx_reg <= idx_reg + 5'd1;
          end
        end

        IP: begin
          if (!gmii_rx_dv) begin
            drop_cnt  <= sat_inc(drop_cnt);
            state_reg <= HUNT;
          end else if (ip_fail) begin
            drop_cnt  <= sat_inc(drop_cnt);
            state_reg <= DROP;
          end else begin
            if (idx_reg[0]) sum_reg <= sum_next;
            if (idx_reg == 5'd3) ip_len_reg <= word16;
            if (idx_reg == 5'd19) begin
              state_reg <= UDP;
              idx_reg   <= '0;
            end else begin
              idx_reg <= idx_reg + 5'd1;
            end
          end
        end

        UDP: begin
          if (!gmii_rx_dv) begin
            drop_cnt  <= sat_inc(drop_cnt);
            state_reg <= HUNT;
          end else if (udp_fail) begin
            drop_cnt  <= sat_inc(drop_cnt);
            state_reg <= DROP;
          end else begin
            if (idx_reg == 5'd5) pay_cnt_reg <= word16 - 16'd8;
            if (idx_reg == 5'd7) begin
              state_reg <= (pay_cnt_reg == 16'd0) ? TAIL : PAY;
              first_reg <= 1'b1;
              idx_reg   <= '0;
            end else begin
              idx_reg <= idx_reg + 5'd1;
            end
          end
        end

        PAY, TAIL: begin
          if (!gmii_rx_dv) begin
            // Verdict: only a frame that streamed its whole payload can be good.
            frame_done <= 1'b1;
            frame_ok   <= crc_good && !er_seen_reg && (state_reg == TAIL);
            if (crc_good && !er_seen_reg && (state_reg == TAIL)) ok_cnt <= sat_inc(ok_cnt);
            if (!crc_good) crc_err_cnt <= sat_inc(crc_err_cnt);
            state_reg <= HUNT;
          end else if (state_reg == PAY) begin
            m_valid     <= 1'b1;
            m_data      <= gmii_rxd;
            m_sof       <= first_reg;
            m_last      <= (pay_cnt_reg == 16'd1);
            first_reg   <= 1'b0;
            pay_cnt_reg <= pay_cnt_reg - 16'd1;
            if (pay_cnt_reg == 16'd1) state_reg <= TAIL;
          end
        end

        DROP: begin
          if (!gmii_rx_dv) state_reg <= HUNT;
        end

        default: state_reg <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_rx_parser.sv
// Testbench for udp_rx_parser. Frames are built as byte queues. A byte-level
// parser of the frame rules predicts the payload, verdict and counters.
module tb_udp_rx_parser;
  localparam logic [47:0] LOCAL_MAC  = 48'h02_11_22_33_44_66;
  localparam logic [47:0] BCAST_MAC  = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] LOCAL_IP   = 32'hC0A8_F002;
  localparam logic [31:0] BCAST_IP   = 32'hC0A8_F0FF;
  localparam logic [15:0] LOCAL_PORT = 16'd6002;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int n_pay;
    bit last;
    bit done;
    bit ok;
    bit crc_bad;
    bit drop;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  gmii_rxd = 8'h00;
  logic        gmii_rx_dv = 1'b0;
  logic        gmii_rx_er = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid, m_sof, m_last, frame_done, frame_ok;
  logic [15:0] ok_cnt, crc_err_cnt, drop_cnt;

  udp_rx_parser dut (
    .clk(clk), .rst(rst), .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv),
    .gmii_rx_er(gmii_rx_er), .m_data(m_data), .m_valid(m_valid), .m_sof(m_sof),
    .m_last(m_last), .frame_done(frame_done), .frame_ok(frame_ok),
    .ok_cnt(ok_cnt), .crc_err_cnt(crc_err_cnt), .drop_cnt(drop_cnt)
  );

  always #4 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_ok = 0, exp_crc = 0, exp_drop = 0;

  logic [7:0] got_q[$];
  int         sof_q[$];
  int         last_q[$];
  bit         done_q[$];

  // Output monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (m_valid) begin
      got_q.push_back(m_data);
      if (m_sof)  sof_q.push_back(got_q.size() - 1);
      if (m_last) last_q.push_back(got_q.size() - 1);
    end
    if (frame_done) done_q.push_back(frame_ok);
  end

  task automatic chk(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] fcs_of(input bq_t f, input int len);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < len; i++) begin
      c ^= {24'h0, f[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t build(input logic [47:0] dmac, input logic [31:0] dip,
                                input logic [15:0] dport, input int plen,
                                input bit rnd, input bit bad_csum);
    bq_t f;
    logic [7:0]  ip[20];
    logic [31:0] s;
    logic [15:0] cs, tot, ul;
    logic [31:0] fcs;
    tot = 16'(plen + 28);
    ul  = 16'(plen + 8);
    for (int i = 0; i < 6; i++) f.push_back(dmac[47-8*i -: 8]);
    f = {f, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h08, 8'h00};
    ip = '{8'h45, 8'h00, tot[15:8], tot[7:0], 8'h00, 8'h00, 8'h40, 8'h00,
           8'h40, 8'h11, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'hF0, 8'h01,
           dip[31:24], dip[23:16], dip[15:8], dip[7:0]};
    s = 0;
    for (int w = 0; w < 10; w++) s += {16'h0, ip[2*w], ip[2*w+1]};
    while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    cs = ~s[15:0] + 16'(bad_csum);
    ip[10] = cs[15:8];
    ip[11] = cs[7:0];
    for (int i = 0; i < 20; i++) f.push_back(ip[i]);
    f = {f, 8'h17, 8'h71, dport[15:8], dport[7:0], ul[15:8], ul[7:0], 8'h00, 8'h00};
    for (int i = 0; i < plen; i++) f.push_back(rnd ? 8'($urandom()) : 8'(i));
    while (f.size() < 60) f.push_back(8'h00);
    fcs = fcs_of(f, f.size());
    f = {f, fcs[7:0], fcs[15:8], fcs[23:16], fcs[31:24]};
    return f;
  endfunction

  // Predicts the observable result for the bytes actually sent after the SFD.
  function automatic exp_t model(input bq_t f, input bit er);
    exp_t        e;
    int          n, plen, avail;
    logic [47:0] dmac;
    logic [31:0] dip, s;
    logic [15:0] tot, ulen, dport;
    bit          hdr_ok, fcs_ok;
    e = '{0, 0, 0, 0, 0, 0};
    n = f.size();
    if (n < 42) begin
      e.drop = 1;
      return e;
    end
    dmac  = {f[0], f[1], f[2], f[3], f[4], f[5]};
    tot   = {f[16], f[17]};
    dip   = {f[30], f[31], f[32], f[33]};
    dport = {f[36], f[37]};
    ulen  = {f[38], f[39]};
    s = 0;
    for (int w = 0; w < 10; w++) s += {16'h0, f[14+2*w], f[15+2*w]};
    while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    hdr_ok = (dmac == LOCAL_MAC || dmac == BCAST_MAC) && ({f[12], f[13]} == 16'h0800) &&
             (f[14] == 8'h45) && (f[23] == 8'd17) && (({f[20], f[21]} & 16'h3FFF) == 0) &&
             (dip == LOCAL_IP || dip == BCAST_IP) && (s[15:0] == 16'hFFFF) &&
             (dport == LOCAL_PORT) && (ulen >= 8) && (int'(ulen) + 20 == int'(tot));
    if (!hdr_ok) begin
      e.drop = 1;
      return e;
    end
    plen    = int'(ulen) - 8;
    avail   = n - 42;
    e.n_pay = (avail < plen) ? avail : plen;
    e.last  = (avail >= plen) && (plen > 0);
    e.done  = 1;
    fcs_ok  = (fcs_of(f, n - 4) == {f[n-1], f[n-2], f[n-3], f[n-4]});
    e.crc_bad = !fcs_ok;
    e.ok    = fcs_ok && !er && (avail >= plen);
    return e;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, " m_data"}, m_data, 0);
    chk({tag, " m_valid"}, m_valid, 0);
    chk({tag, " m_sof"}, m_sof, 0);
    chk({tag, " m_last"}, m_last, 0);
    chk({tag, " frame_done"}, frame_done, 0);
    chk({tag, " frame_ok"}, frame_ok, 0);
    chk({tag, " ok_cnt"}, ok_cnt, 0);
    chk({tag, " crc_err_cnt"}, crc_err_cnt, 0);
    chk({tag, " drop_cnt"}, drop_cnt, 0);
  endtask

  task automatic clear_mon();
    got_q.delete();
    sof_q.delete();
    last_q.delete();
    done_q.delete();
  endtask

  // Preamble of 7 x 0x55 plus SFD, then the frame, then ifg idle cycles.
  task automatic send(input bq_t f, input int er_idx, input int rst_idx, input int ifg);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      gmii_rxd = (i == 7) ? 8'hD5 : 8'h55;
      gmii_rx_dv = 1'b1;
      gmii_rx_er = 1'b0;
    end
    for (int i = 0; i < f.size(); i++) begin
      @(posedge clk); #1;
      if (rst_idx >= 0 && i == rst_idx + 1) check_zero("midreset");
      gmii_rxd = f[i];
      gmii_rx_dv = 1'b1;
      gmii_rx_er = (i == er_idx);
      rst = (i == rst_idx);
    end
    @(posedge clk); #1;
    gmii_rxd = 8'h00;
    gmii_rx_dv = 1'b0;
    gmii_rx_er = 1'b0;
    rst = 1'b0;
    repeat (ifg - 1) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input bq_t f, input exp_t e);
    int bad;
    bad = -1;
    chk({tag, " pay_count"}, got_q.size(), e.n_pay);
    for (int i = 0; i < got_q.size() && i < e.n_pay; i++) begin
      if (bad < 0 && got_q[i] !== f[42+i]) bad = i;
    end
    chk({tag, " first_bad_byte"}, bad, -1);
    chk({tag, " sof_count"}, sof_q.size(), (e.n_pay > 0) ? 1 : 0);
    chk({tag, " sof_index"}, (sof_q.size() > 0) ? sof_q[0] : -1, (e.n_pay > 0) ? 0 : -1);
    chk({tag, " last_count"}, last_q.size(), e.last);
    chk({tag, " last_index"}, (last_q.size() > 0) ? last_q[0] : -1, e.last ? e.n_pay - 1 : -1);
    chk({tag, " done_count"}, done_q.size(), e.done);
    chk({tag, " frame_ok"}, (done_q.size() > 0) ? done_q[0] : 1'b0, e.ok);
    if (e.drop) exp_drop++;
    if (e.done && e.ok) exp_ok++;
    if (e.done && e.crc_bad) exp_crc++;
    chk({tag, " ok_cnt"}, ok_cnt, exp_ok);
    chk({tag, " crc_err_cnt"}, crc_err_cnt, exp_crc);
    chk({tag, " drop_cnt"}, drop_cnt, exp_drop);
    $display("frame %s: pay=%0d done=%0d ok=%0d cnts ok=%0d crc=%0d drop=%0d",
             tag, got_q.size(), done_q.size(), (done_q.size() > 0) ? done_q[0] : 1'b0,
             ok_cnt, crc_err_cnt, drop_cnt);
    clear_mon();
  endtask

  initial begin
    bq_t  f, f2;
    exp_t e;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Loopback-style broadcast frame with 512-byte incrementing payload.
    f = build(BCAST_MAC, BCAST_IP, LOCAL_PORT, 512, 1'b0, 1'b0);
    e = model(f, 1'b0);
    send(f, -1, -1, 12);
    chk("loopback byte511", (got_q.size() == 512) ? got_q[511] : -1, 255);
    check_frame("loopback", f, e);
    chk("loopback ok_cnt_is_1", ok_cnt, 1);

    // Payload byte 100 corrupted after the FCS was computed.
    f = build(BCAST_MAC, BCAST_IP, LOCAL_PORT, 512, 1'b0, 1'b0);
    f[42+100] ^= 8'h01;
    e = model(f, 1'b0);
    send(f, -1, -1, 12);
    check_frame("payload_flip", f, e);

    // Wrong UDP port, then IP checksum off by one.
    f = build(BCAST_MAC, BCAST_IP, 16'd6003, 64, 1'b1, 1'b0);
    e = model(f, 1'b0);
    send(f, -1, -1, 12);
    check_frame("port6003", f, e);
    f = build(LOCAL_MAC, LOCAL_IP, LOCAL_PORT, 64, 1'b1, 1'b1);
    e = model(f, 1'b0);
    send(f, -1, -1, 12);
    check_frame("bad_csum", f, e);

    // rx_er on payload byte 10 of an otherwise good frame.
    f = build(LOCAL_MAC, LOCAL_IP, LOCAL_PORT, 100, 1'b1, 1'b0);
    e = model(f, 1'b1);
    send(f, 42 + 10, -1, 12);
    check_frame("rx_er", f, e);

    // Truncated after 200 payload bytes.
    f  = build(LOCAL_MAC, LOCAL_IP, LOCAL_PORT, 300, 1'b1, 1'b0);
    f2 = f[0:42+199];
    e  = model(f2, 1'b0);
    send(f2, -1, -1, 12);
    check_frame("truncated", f2, e);

    // Reset on payload byte 50: no verdict, counters cleared.
    f = build(LOCAL_MAC, LOCAL_IP, LOCAL_PORT, 100, 1'b1, 1'b0);
    send(f, -1, 42 + 50, 12);
    chk("rst_frame pay_count", got_q.size(), 50);
    chk("rst_frame done_count", done_q.size(), 0);
    chk("rst_frame ok_cnt", ok_cnt, 0);
    chk("rst_frame drop_cnt", drop_cnt, 0);
    $display("frame rst_frame: pay=%0d done=%0d", got_q.size(), done_q.size());
    clear_mon();
    exp_ok = 0;
    exp_crc = 0;
    exp_drop = 0;

    // Frame after reset, 1-byte payload (m_sof and m_last together).
    f = build(LOCAL_MAC, BCAST_IP, LOCAL_PORT, 1, 1'b1, 1'b0);
    e = model(f, 1'b0);
    send(f, -1, -1, 12);
    chk("one_byte sof_eq_last", (sof_q.size() > 0 && last_q.size() > 0) ? (sof_q[0] == last_q[0]) : 0, 1);
    check_frame("one_byte", f, e);

    // Two back-to-back zero-payload frames, padded to 60 bytes.
    f = build(BCAST_MAC, LOCAL_IP, LOCAL_PORT, 0, 1'b0, 1'b0);
    send(f, -1, -1, 12);
    send(f, -1, -1, 12);
    chk("b2b pay_count", got_q.size(), 0);
    chk("b2b done_count", done_q.size(), 2);
    chk("b2b ok0", (done_q.size() > 0) ? done_q[0] : 1'b0, 1);
    chk("b2b ok1", (done_q.size() > 1) ? done_q[1] : 1'b0, 1);
    exp_ok += 2;
    chk("b2b ok_cnt", ok_cnt, exp_ok);
    $display("frame b2b: done=%0d ok_cnt=%0d", done_q.size(), ok_cnt);
    clear_mon();

    // Randomized frames with random filtering fields and corruptions.
    for (int k = 0; k < 20; k++) begin
      logic [47:0] dm;
      logic [31:0] di;
      logic [15:0] dp;
      int          pl, er, r, j;
      case ($urandom_range(0, 3))
        0:       dm = LOCAL_MAC;
        1, 2:    dm = BCAST_MAC;
        default: dm = {16'h0211, 32'($urandom())};
      endcase
      case ($urandom_range(0, 3))
        0:       di = LOCAL_IP;
        1, 2:    di = BCAST_IP;
        default: di = {24'hC0A8F0, 8'($urandom())};
      endcase
      dp = ($urandom_range(0, 5) == 0) ? 16'd6003 : LOCAL_PORT;
      pl = $urandom_range(0, 60);
      f  = build(dm, di, dp, pl, 1'b1, ($urandom_range(0, 7) == 0));
      er = -1;
      r  = $urandom_range(0, 5);
      if (r == 0) begin
        j = $urandom_range(0, f.size() - 1);
        f[j] ^= 8'h10;
      end else if (r == 1) begin
        er = $urandom_range(0, f.size() - 1);
      end else if (r == 2) begin
        j = $urandom_range(30, f.size() - 2);
        f = f[0:j];
      end
      e = model(f, er >= 0);
      send(f, er, -1, 12);
      check_frame($sformatf("rand%0d", k), f, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_rx_parser.md
# udp_rx_parser

GMII receive-side IPv4/UDP frame parser for the 1000BASE-T datapath at 125 MHz. It hunts preamble/SFD, checks the Ethernet FCS, and filters on MAC, EtherType, IPv4 header and UDP destination port. Matching UDP payload bytes are streamed out as they arrive; a per-frame good/bad verdict follows once the FCS has been received. It is the receive counterpart of the team's UDP broadcast transmitter and consumes exactly that frame format, including loopback from it.

## Interface
Parameters:
- LOCAL_MAC, 48'h02_11_22_33_44_66: unicast MAC accepted.
- ACCEPT_BCAST, 1: also accept destination MAC FF:FF:FF:FF:FF:FF.
- LOCAL_IP, 32'hC0A8_F002: unicast IP accepted.
- BCAST_IP, 32'hC0A8_F0FF: subnet broadcast IP accepted.
- LOCAL_PORT, 16'd6002: UDP destination port accepted.

Ports:
- clk  in  1  125 MHz GMII RX clock.
- rst  in  1  reset; synchronous, active-high.
- gmii_rxd  in  8  receive data.
- gmii_rx_dv  in  1  receive data valid.
- gmii_rx_er  in  1  receive error.
- m_data  out  8  payload byte.
- m_valid  out  1  payload byte strobe.
- m_sof  out  1  first payload byte of a frame; qualified by m_valid.
- m_last  out  1  last payload byte of a frame, per UDP length; qualified by m_valid.
- frame_done  out  1  one-cycle verdict pulse for an accepted frame.
- frame_ok  out  1  verdict; valid only while frame_done is high.
- ok_cnt  out  16  frames with a good verdict; saturates at 0xFFFF.
- crc_err_cnt  out  16  accepted frames with an FCS mismatch; saturates.
- drop_cnt  out  16  frames rejected by the filter or header checks; saturates.

## Operation
States: WAIT_IDLE, HUNT, ETH, IP, UDP, PAY, TAIL, DROP.

- **Reset.** The block enters WAIT_IDLE. All outputs are 0 and all counters are 0.
- **WAIT_IDLE.** Waits for gmii_rx_dv=0, then moves to HUNT. This avoids locking onto a frame already in progress.
- **HUNT.** Accepts 0x55 bytes while gmii_rx_dv=1.
  - 0xD5 after at least one 0x55: CRC register set to 0xFFFFFFFF, go to ETH.
  - Any other byte: go to DROP with no drop_cnt increment.
- **CRC.** Reflected polynomial 0xEDB88320, processed LSB-first. It runs over every byte after the SFD, including the FCS. The frame is good iff the register equals 0xDEBB20E3 on the sample where rx_dv falls.
- **ETH (14 bytes).** Destination MAC must equal LOCAL_MAC, or be all-ones when ACCEPT_BCAST=1. EtherType must be 0x0800.
- **IP (20 bytes).** Checks:
  - byte 0 = 0x45;
  - protocol = 17;
  - (bytes 6..7 & 0x3FFF) = 0, i.e. no fragments;
  - destination IP is LOCAL_IP or BCAST_IP;
  - the one's-complement sum of the 10 header words with end-around carry equals 0xFFFF.
  
  IP total length is latched.
- **UDP (8 bytes).** Destination port must equal LOCAL_PORT. UDP length must be ≥ 8 and must equal IP total length − 20. The payload count is set to UDP length − 8.
- **Header failure.** Any failed check sends the block to DROP, increments drop_cnt, emits no payload and no frame_done.
- **PAY.** Each byte is emitted with m_valid. m_sof is set on the first byte and m_last on the byte where the count reaches 0. Then go to TAIL.
- **Zero-length payload.** No m_valid is issued; go straight to TAIL.
- **TAIL.** Consumes padding and FCS bytes, CRC only.
- **Verdict.** On the first rx_dv=0 sample after ETH has been entered:
  - If the frame reached PAY or TAIL: assert frame_done.
  - frame_ok = CRC residue match AND no gmii_rx_er seen during the frame AND the payload completed (state was TAIL).
  - If frame_ok: ok_cnt++. If the CRC residue fails: crc_err_cnt++.
  - If rx_dv falls during ETH, IP or UDP: drop_cnt++ and no frame_done.
  - Then go to HUNT.
- **DROP.** Waits for rx_dv=0, then goes to HUNT.
- **Backpressure.** None. Downstream must accept every m_valid byte and discard the frame's payload when frame_ok=0.

## Timing
- Inputs are sampled at posedge clk. All outputs are registered.
- A byte sampled at edge k appears on m_data/m_valid after edge k, i.e. 1-cycle latency.
- frame_done/frame_ok update at the edge that samples the first rx_dv=0. The counters update at the same edge.
- m_valid is contiguous within a frame. m_sof and m_last coincide for a 1-byte payload.
- The block handles back-to-back frames with a 12-cycle IFG and a 7-byte preamble.
- Header checks are evaluated on the last byte of each header field. The failure transition takes effect on the next byte.
- Reset asserted mid-frame: on the following edge all outputs are 0 and counters cleared, with no frame_done for the aborted frame. The block then waits in WAIT_IDLE.

## Test plan
- **Loopback of the transmitter** (512-byte incrementing payload, dst MAC FF.., dst IP 192.168.240.255, port 6002) → 512 m_valid bytes 0x00..0xFF twice; m_sof on byte 0; m_last on byte 511; frame_done with frame_ok=1; ok_cnt=1.
- **Same frame, payload byte 100 XORed with 0x01** → 512 bytes streamed; frame_ok=0; crc_err_cnt=1; ok_cnt unchanged.
- **Destination port 6003, or IP header checksum off by 1** → no m_valid, no frame_done; drop_cnt=1.
- **gmii_rx_er pulsed on payload byte 10 of a good-CRC frame** → frame_done with frame_ok=0; crc_err_cnt unchanged.
- **Frame truncated after 200 payload bytes** → 200 bytes, no m_last, frame_ok=0. **Reset asserted on payload byte 50 of the next frame** → outputs 0, no verdict, and the third frame is received correctly.
- **Two back-to-back frames, IFG 12, with UDP length 8 (zero payload, padded to 60 bytes)** → no m_valid; two frame_done pulses with frame_ok=1; ok_cnt=2.
